decode_pipe_stage: RTL and testbench

//  RV32I decode stage plus ID/EX pipeline register. Decodes the full RV32I integer set into a

---
 rtl/ctl_pkg.sv | 112 +++++++++++
 rtl/decode_comb.sv | 160 ++++++++++++++++
 rtl/decode_pipe_stage.sv | 103 ++++++++++
 tb/tb_decode_pipe_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ctl_pkg.sv
// ---------------------------------------------------------------------------
// ctl_pkg
//   Shared RV32I decode constants for the pipeline: opcode / funct3 / funct7
//   encodings, ALU opcode and branch-type codes, the control-word struct and
//   the bit position of every control field.
//   The control word is 32 bits, MSB first:
//     [31:29] br_type  [28:25] alu_op  [24] jal  [23] jalr  [22] lui
//     [21] auipc  [20] alu_src  [19] mem_to_reg  [18] ra_to_reg
//     [17] mem_read  [16] mem_write  [15] reg_write  [14:12] mem_size
//     [11] illegal  [10:0] reserved (always 0)
// ---------------------------------------------------------------------------
package ctl_pkg;

    // Major opcodes (ir[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct3 codes shared by OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 codes for conditional branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // The only two legal SYSTEM encodings in RV32I
    localparam logic [31:0] IR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] IR_EBREAK = 32'h0010_0073;

    // ALU opcodes
    localparam logic [3:0] ALU_OP_SUB  = 4'd0;
    localparam logic [3:0] ALU_OP_ADD  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_SRL  = 4'd5;
    localparam logic [3:0] ALU_OP_SLL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_SLT  = 4'd8;
    localparam logic [3:0] ALU_OP_SLTU = 4'd9;

    // Branch types
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;

    // Control-word bit positions
    localparam int CTL_BR_LSB       = 29;
    localparam int CTL_ALU_LSB      = 25;
    localparam int CTL_JAL          = 24;
    localparam int CTL_JALR         = 23;
    localparam int CTL_LUI          = 22;
    localparam int CTL_AUIPC        = 21;
    localparam int CTL_ALU_SRC      = 20;
    localparam int CTL_MEM_TO_REG   = 19;
    localparam int CTL_RA_TO_REG    = 18;
    localparam int CTL_MEM_READ     = 17;
    localparam int CTL_MEM_WRITE    = 16;
    localparam int CTL_REG_WRITE    = 15;
    localparam int CTL_MEM_SIZE_LSB = 12;
    localparam int CTL_ILLEGAL      = 11;

    // Packed view of the same layout; field order matches the bit positions.
    typedef struct packed {
        logic [2:0]  br_type;
        logic [3:0]  alu_op;
        logic        jal;
        logic        jalr;
        logic        lui;
        logic        auipc;
        logic        alu_src;
        logic        mem_to_reg;
        logic        ra_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [2:0]  mem_size;
        logic        illegal;
        logic [10:0] rsvd;
    } ctl_t;

    // Word emitted for any undecodable instruction: only the illegal flag.
    localparam logic [31:0] CTL_ILLEGAL_WORD = 32'h1 << CTL_ILLEGAL;

endpackage

// File: rtl/decode_comb.sv
// ---------------------------------------------------------------------------
// decode_comb
//   Purely combinational RV32I decoder.
//   Ports:
//     ir        in   32     instruction word
//     ctl       out  ctl_t  control word (illegal encodings -> illegal bit only)
//     uses_rs1  out  1      instruction reads rs1
//     uses_rs2  out  1      instruction reads rs2
// ---------------------------------------------------------------------------
module decode_comb
    import ctl_pkg::*;
#(
    parameter int ALU_OP_W = 4
) (
    input  logic [31:0] ir,
    output ctl_t        ctl,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    ctl_t       dec;
    logic [3:0] alu_sel;
    logic       bad;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statements can leave one unassigned (no latch).
        dec      = '0;
        alu_sel  = ALU_OP_ADD;
        bad      = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;

        unique case (opcode)
            OPC_LUI: begin
                dec.lui       = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            OPC_AUIPC: begin
                dec.auipc     = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            OPC_JAL: begin
                dec.jal       = 1'b1;
                dec.ra_to_reg = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b0;
            end
            OPC_JALR: begin
                dec.jalr      = 1'b1;
                dec.ra_to_reg = 1'b1;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                bad           = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                alu_sel  = ALU_OP_SUB;
                uses_rs2 = 1'b1;
                case (funct3)
                    F3_BEQ:  dec.br_type = BR_BEQ;
                    F3_BNE:  dec.br_type = BR_BNE;
                    F3_BLT:  dec.br_type = BR_BLT;
                    F3_BGE:  dec.br_type = BR_BGE;
                    F3_BLTU: dec.br_type = BR_BLTU;
                    F3_BGEU: dec.br_type = BR_BGEU;
                    default: bad = 1'b1;   // 010 / 011 are unassigned
                endcase
            end
            OPC_LOAD: begin
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_size   = funct3;
                // LB LH LW LBU LHU only
                bad = !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_size  = funct3;
                uses_rs2      = 1'b1;
                bad           = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct3)
                    F3_ADD:  alu_sel = ALU_OP_ADD;
                    F3_SLT:  alu_sel = ALU_OP_SLT;
                    F3_SLTU: alu_sel = ALU_OP_SLTU;
                    F3_XOR:  alu_sel = ALU_OP_XOR;
                    F3_OR:   alu_sel = ALU_OP_OR;
                    F3_AND:  alu_sel = ALU_OP_AND;
                    F3_SLL: begin
                        alu_sel = ALU_OP_SLL;
                        bad     = (funct7 != F7_BASE);
                    end
                    default: begin   // F3_SR: SRLI / SRAI by funct7
                        if (funct7 == F7_BASE)     alu_sel = ALU_OP_SRL;
                        else if (funct7 == F7_ALT) alu_sel = ALU_OP_SRA;
                        else                       bad     = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                dec.reg_write = 1'b1;
                uses_rs2      = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD:  alu_sel = ALU_OP_ADD;
                        F3_SLL:  alu_sel = ALU_OP_SLL;
                        F3_SLT:  alu_sel = ALU_OP_SLT;
                        F3_SLTU: alu_sel = ALU_OP_SLTU;
                        F3_XOR:  alu_sel = ALU_OP_XOR;
                        F3_SR:   alu_sel = ALU_OP_SRL;
                        F3_OR:   alu_sel = ALU_OP_OR;
                        default: alu_sel = ALU_OP_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    alu_sel = ALU_OP_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    alu_sel = ALU_OP_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_MISC_MEM: begin
                // FENCE: legal, but has no effect in this in-order pipeline.
                alu_sel = ALU_OP_SUB;
                bad     = (funct3 != 3'b000);
            end
            OPC_SYSTEM: begin
                // ECALL / EBREAK decode to an all-zero word; trap handling is
                // done elsewhere from ex_ir.
                alu_sel = ALU_OP_SUB;
                bad     = (ir != IR_ECALL) && (ir != IR_EBREAK);
            end
            default: bad = 1'b1;
        endcase

        // Codes are carried at ALU_OP_W bits and packed into the 4-bit field.
        dec.alu_op = 4'(ALU_OP_W'(alu_sel));
    end

    assign ctl = bad ? ctl_t'(CTL_ILLEGAL_WORD) : dec;

endmodule

// File: rtl/decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// decode_pipe_stage
//   RV32I decode stage plus the ID/EX pipeline register. Adds load-use
//   hazard detection (bubble insertion), stall/flush handling and a
//   saturating count of inserted bubbles.
//   Ports:
//     clk           in   1      clock, rising edge
//     rst           in   1      asynchronous reset, active-high
//     id_valid      in   1      id_ir holds a real instruction
//     id_ir         in   32     instruction from IF/ID
//     id_ready      out  1      ID/EX accepts id_ir this cycle
//     ex_ready      in   1      EX can take the ID/EX contents this cycle
//     flush         in   1      kill ID/EX contents
//     ex_valid      out  1      ID/EX holds a real instruction
//     ex_ctl        out  CTL_W  registered control word (bits above 31 = 0)
//     ex_ir         out  32     registered instruction
//     hazard_stall  out  1      combinational load-use stall
//     bubble_cnt    out  CNT_W  saturating count of hazard bubbles
// ---------------------------------------------------------------------------
module decode_pipe_stage
    import ctl_pkg::*;
#(
    parameter int CTL_W     = 32,
    parameter int ALU_OP_W  = 4,
    parameter bit HAZARD_EN = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [31:0]      id_ir,
    output logic             id_ready,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             ex_valid,
    output logic [CTL_W-1:0] ex_ctl,
    output logic [31:0]      ex_ir,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctl_t dec_ctl;
    logic dec_uses_rs1;
    logic dec_uses_rs2;

    decode_comb #(
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .ir       (id_ir),
        .ctl      (dec_ctl),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2)
    );

    // Load-use hazard: the load in EX returns its data too late for the
    // instruction in ID, so one bubble is needed. x0 never creates one.
    logic [4:0] ex_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       load_use;

    assign ex_rd  = ex_ir[11:7];
    assign id_rs1 = id_ir[19:15];
    assign id_rs2 = id_ir[24:20];

    assign load_use = id_valid && ex_valid && ex_ctl[CTL_MEM_READ] && (ex_rd != 5'd0) &&
                      ((dec_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (dec_uses_rs2 && (id_rs2 == ex_rd)));

    assign hazard_stall = HAZARD_EN && load_use;
    assign id_ready     = ex_ready && !hazard_stall;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_ctl     <= '0;
            ex_ir      <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            // Flush wins even over a hold; the instruction in ID is dropped.
            ex_valid <= 1'b0;
            ex_ctl   <= '0;
        end else if (ex_ready) begin
            if (hazard_stall) begin
                // The bubble clears ex_valid, so the stall drops next cycle
                // and the waiting instruction issues then.
                ex_valid <= 1'b0;
                ex_ctl   <= '0;
                if (!(&bubble_cnt)) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end else begin
                ex_valid <= id_valid;
                ex_ir    <= id_ir;
                ex_ctl   <= id_valid ? CTL_W'(dec_ctl) : '0;
            end
        end
        // ex_ready low without flush: everything holds.
    end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe_stage
//   Directed bench for decode_pipe_stage. Three instances share the stimulus:
//   u_dut (defaults), u_nohz (HAZARD_EN=0) and u_sat (CNT_W=3, so counter
//   saturation is reachable in a few dozen cycles).
// ---------------------------------------------------------------------------
module tb_decode_pipe_stage;

    localparam logic [31:0] IR_ADD   = 32'h0020_81B3;  // add  x3,x1,x2
    localparam logic [31:0] IR_LW    = 32'h0000_A283;  // lw   x5,0(x1)
    localparam logic [31:0] IR_ADD2  = 32'h0012_8333;  // add  x6,x5,x1
    localparam logic [31:0] IR_BGE   = 32'h0020_D463;  // bge  x1,x2,8
    localparam logic [31:0] IR_SLTIU = 32'h0010_B293;  // sltiu x5,x1,1
    localparam logic [31:0] IR_SRAI  = 32'h4030_D293;  // srai x5,x1,3
    localparam logic [31:0] IR_BAD   = 32'hFFFF_FFFF;

    // Hand-derived control words
    localparam logic [31:0] CTL_ADD   = 32'h0200_8000;  // alu ADD, reg_write
    localparam logic [31:0] CTL_LW    = 32'h021A_A000;  // ADD, alu_src, m2r, mem_read, rw, size 010
    localparam logic [31:0] CTL_BGE   = 32'h8000_0000;  // br_type 4, alu SUB
    localparam logic [31:0] CTL_SLTIU = 32'h1210_8000;  // alu 9, alu_src, rw
    localparam logic [31:0] CTL_SRAI  = 32'h0E10_8000;  // alu 7, alu_src, rw
    localparam logic [31:0] CTL_BAD   = 32'h0000_0800;  // illegal only

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [31:0] id_ir = '0;
    logic        ex_ready = 1'b0;
    logic        flush = 1'b0;

    logic        d_id_ready, d_ex_valid, d_hazard;
    logic [31:0] d_ex_ctl, d_ex_ir;
    logic [15:0] d_bubble;

    logic        n_id_ready, n_ex_valid, n_hazard;
    logic [31:0] n_ex_ctl, n_ex_ir;
    logic [15:0] n_bubble;

    logic        s_id_ready, s_ex_valid, s_hazard;
    logic [31:0] s_ex_ctl, s_ex_ir;
    logic [2:0]  s_bubble;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_pipe_stage u_dut (
        .clk (clk), .rst (rst), .id_valid (id_valid), .id_ir (id_ir),
        .id_ready (d_id_ready), .ex_ready (ex_ready), .flush (flush),
        .ex_valid (d_ex_valid), .ex_ctl (d_ex_ctl), .ex_ir (d_ex_ir),
        .hazard_stall (d_hazard), .bubble_cnt (d_bubble)
    );

    decode_pipe_stage #(.HAZARD_EN (1'b0)) u_nohz (
        .clk (clk), .rst (rst), .id_valid (id_valid), .id_ir (id_ir),
        .id_ready (n_id_ready), .ex_ready (ex_ready), .flush (flush),
        .ex_valid (n_ex_valid), .ex_ctl (n_ex_ctl), .ex_ir (n_ex_ir),
        .hazard_stall (n_hazard), .bubble_cnt (n_bubble)
    );

    decode_pipe_stage #(.CNT_W (3)) u_sat (
        .clk (clk), .rst (rst), .id_valid (id_valid), .id_ir (id_ir),
        .id_ready (s_id_ready), .ex_ready (ex_ready), .flush (flush),
        .ex_valid (s_ex_valid), .ex_ctl (s_ex_ctl), .ex_ir (s_ex_ir),
        .hazard_stall (s_hazard), .bubble_cnt (s_bubble)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- Reset: asynchronous, checked before the first clock edge ----
        #1 rst = 1'b1;
        #1;
        check("rst_ex_valid", 32'(d_ex_valid), 32'd0);
        check("rst_ex_ctl",   d_ex_ctl,        32'd0);
        check("rst_ex_ir",    d_ex_ir,         32'd0);
        check("rst_bubble",   32'(d_bubble),   32'd0);
        tick();
        tick();
        rst = 1'b0;

        // ---- T1: plain ADD, one-cycle latency ----
        id_valid = 1'b1;
        ex_ready = 1'b1;
        id_ir    = IR_ADD;
        #1;
        check("t1_id_ready", 32'(d_id_ready), 32'd1);
        tick();
        check("t1_ex_valid", 32'(d_ex_valid), 32'd1);
        check("t1_ex_ctl",   d_ex_ctl,        CTL_ADD);
        check("t1_ex_ir",    d_ex_ir,         IR_ADD);

        // ---- T2: load-use hazard ----
        id_ir = IR_LW;
        tick();
        check("t2_lw_ctl", d_ex_ctl, CTL_LW);
        id_ir = IR_ADD2;
        #1;
        check("t2_stall",       32'(d_hazard),   32'd1);
        check("t2_id_ready",    32'(d_id_ready), 32'd0);
        check("t2_nohz_stall",  32'(n_hazard),   32'd0);
        check("t2_nohz_ready",  32'(n_id_ready), 32'd1);
        tick();
        check("t2_bubble_valid", 32'(d_ex_valid), 32'd0);
        check("t2_bubble_ctl",   d_ex_ctl,        32'd0);
        check("t2_bubble_cnt",   32'(d_bubble),   32'd1);
        check("t2_stall_clear",  32'(d_hazard),   32'd0);
        check("t2_ready_back",   32'(d_id_ready), 32'd1);
        check("t2_nohz_valid",   32'(n_ex_valid), 32'd1);
        check("t2_nohz_ir",      n_ex_ir,         IR_ADD2);
        tick();
        check("t2_add_valid", 32'(d_ex_valid), 32'd1);
        check("t2_add_ir",    d_ex_ir,         IR_ADD2);
        check("t2_add_ctl",   d_ex_ctl,        CTL_ADD);
        check("t2_cnt_kept",  32'(d_bubble),   32'd1);

        // ---- T3: branch and immediate decodes ----
        id_ir = IR_BGE;
        tick();
        check("t3_bge_ctl", d_ex_ctl, CTL_BGE);
        id_ir = IR_SLTIU;
        tick();
        check("t3_sltiu_ctl", d_ex_ctl, CTL_SLTIU);
        id_ir = IR_SRAI;
        tick();
        check("t3_srai_ctl", d_ex_ctl, CTL_SRAI);

        // ---- T4: downstream hold for 3 cycles, flush in cycle 2 ----
        id_ir = IR_ADD;
        tick();
        ex_ready = 1'b0;
        id_ir    = IR_SRAI;
        #1;
        check("t4_id_ready", 32'(d_id_ready), 32'd0);
        tick();
        check("t4_hold_ctl",   d_ex_ctl,        CTL_ADD);
        check("t4_hold_ir",    d_ex_ir,         IR_ADD);
        check("t4_hold_valid", 32'(d_ex_valid), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_valid", 32'(d_ex_valid), 32'd0);
        check("t4_flush_ctl",   d_ex_ctl,        32'd0);
        tick();
        check("t4_hold3_valid", 32'(d_ex_valid), 32'd0);
        ex_ready = 1'b1;

        // ---- T5: illegal instruction ----
        id_ir = IR_BAD;
        tick();
        check("t5_bad_ctl",   d_ex_ctl,        CTL_BAD);
        check("t5_bad_valid", 32'(d_ex_valid), 32'd1);

        // ---- T5: bubble counter saturation (u_sat has CNT_W=3) ----
        for (int i = 0; i < 9; i++) begin
            id_ir = IR_LW;
            tick();
            id_ir = IR_ADD2;
            tick();
            tick();
            if (i == 5) begin
                check("t5_sat_reach", 32'(s_bubble), 32'd7);
            end
        end
        check("t5_sat_hold",  32'(s_bubble), 32'd7);
        check("t5_dut_count", 32'(d_bubble), 32'd10);
        check("t5_nohz_cnt",  32'(n_bubble), 32'd0);

        // ---- T6: reset asserted between edges acts immediately ----
        id_ir = IR_ADD;
        tick();
        check("t6_pre_valid", 32'(d_ex_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid",  32'(d_ex_valid), 32'd0);
        check("t6_rst_ctl",    d_ex_ctl,        32'd0);
        check("t6_rst_bubble", 32'(d_bubble),   32'd0);
        check("t6_rst_sat",    32'(s_bubble),   32'd0);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
